qam_demapper_ctrl: RTL and testbench
====================================

# qam_demapper_ctrl

Controller and sequencer for `QAM_demapper_datapath`. It runs the calibration pass that derives the I/Q decision thresholds from the incoming 16-QAM constellation. It then gates symbol loads into the datapath and buffers the 4-bit demapped values in a small FIFO. The FIFO drains over a valid/ready handshake toward the downstream bit sink. It sits between the symbol front end and the datapath, on the symbol clock domain.

## Interface
Parameters:
- `CAL_LEN`, 16: symbols per calibration pass; power of two, 4..256.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `DEFAULT_THRESH`, 8'd32: threshold value applied after reset.

Ports:
- `symbol_clock`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  block enable.
- `cal`  in  1  calibration request; level-sensitive.
- `sym_valid`  in  1  a new symbol is present on `I_in`/`Q_in` this cycle.
- `I_in`, `Q_in`  in  8 each  signed symbol components.
- `dp_val`  in  4  demapped value from the datapath; valid the cycle after `dp_load`.
- `dp_load`  out  1  the datapath captures `I_in`/`Q_in` at this edge.
- `thresh_i`, `thresh_q`  out  8 each  unsigned decision thresholds driven to the datapath.
- `data_out`  out  4  FIFO head.
- `data_valid`  out  1  FIFO not empty.
- `data_ready`  in  1  consumer accepts the head at this edge.
- `cal_done`  out  1  one-cycle pulse when new thresholds are applied.
- `overflow`  out  1  sticky flag: a value was dropped because the FIFO was full.

## Operation
- States are IDLE, CAL and RUN. Reset enters IDLE.
- IDLE:
  - `en & cal` → CAL.
  - `en & ~cal` → RUN.
- CAL:
  - Each `sym_valid` adds `|I_in|` to `acc_i` and `|Q_in|` to `acc_q`. The absolute value saturates, so −128 → 127.
  - Accumulator width is 8+log2(`CAL_LEN`); the accumulators cannot overflow.
  - On the `CAL_LEN`-th symbol, `thresh_i = acc_i >> log2(CAL_LEN)` and `thresh_q` likewise. The mean |x| of uniform 16-QAM equals the 2a decision boundary.
  - At the same edge the block pulses `cal_done`, clears the accumulators and the count, and transitions → RUN if `en`, else → IDLE.
  - `en` low in CAL → IDLE. The partial sums are discarded and the thresholds stay unchanged.
  - `dp_load` is held at 0 in CAL.
- RUN:
  - `dp_load = sym_valid & en` (combinational).
  - The block writes `dp_val` into the FIFO at the edge one cycle after `dp_load`.
  - `en` low → IDLE. `cal` high → CAL.
  - An in-flight write from the last RUN `dp_load` still completes in either case.
- FIFO behaviour:
  - A write when full, with no read at the same edge, drops the value and sets `overflow`. `overflow` clears only on `rst`.
  - Read and write at the same edge when full: both occur and nothing is dropped.
  - Read and write at the same edge when empty: the write lands and `data_valid` rises the next cycle. There is no fall-through.
  - A read when empty is ignored.
  - `data_out` is 4'h0 whenever the FIFO is empty.
- Pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally.
- Reset values:
  - `dp_load`, `data_out`, `data_valid`, `cal_done` and `overflow` are 0.
  - `thresh_i` and `thresh_q` are `DEFAULT_THRESH`.
  - The FIFO is empty and the state is IDLE.

## Timing
- `sym_valid` at cycle t: `dp_load` is high during t and the datapath captures at edge t→t+1.
- `dp_val` is sampled at edge t+1→t+2, and `data_out`/`data_valid` are visible from cycle t+2. Latency is 2 cycles from symbol to output.
- Throughput is one symbol per cycle when `data_ready` is held high.
- Calibration: with the `CAL_LEN`-th `sym_valid` at cycle t, the new thresholds and `cal_done` appear in cycle t+1, together with RUN.
- The first `dp_load` can occur at t+1.
- Asserting `rst` mid-operation clears everything immediately and asynchronously. Calibration results that were not yet applied are lost.

## Structure
- The shared package `qam_pkg` holds:
  - state encodings (`ST_IDLE`, `ST_CAL`, `ST_RUN`);
  - `QAM_SYM_W` = 8 and `QAM_VAL_W` = 4;
  - the saturating-abs function, shared with the datapath.
- There is one sub-module, `qam_ctrl_fifo`: a synchronous FIFO with the same clock/reset, a push_drop/overflow output and zero-on-empty output.
- The FSM, calibration accumulators and load gating live in the top level.

## Test plan
- Reset scenario:
  - Stimulus: assert `rst` with `en`=0, then release.
  - Required response: `thresh_i`=`thresh_q`=32, `data_valid`=0, `dp_load`=0 even while `sym_valid`=1.
- Calibration scenario:
  - Stimulus: `en`=`cal`=1. Send 16 symbols with I alternating +20/−60 and Q always −24.
  - Required response: the cycle after the 16th symbol, `cal_done`=1, `thresh_i`=40, `thresh_q`=24, and the state is RUN.
- Saturation scenario:
  - Stimulus: calibrate with all I=−128 and Q=127.
  - Required response: `thresh_i`=`thresh_q`=127.
- Streaming scenario:
  - Stimulus: in RUN with `data_ready`=1, a datapath model returns `dp_val`=4'hA, 4'h3, 4'hF for three back-to-back symbols.
  - Required response: `data_out` is A, 3, F on cycles t+2, t+3 and t+4.
- Overflow scenario:
  - Stimulus: `data_ready`=0, 5 symbols.
  - Required response: 4 entries stored, `overflow`=1 from the 5th write edge onward.
  - Stimulus continues: drain, then one more symbol with a simultaneous read at full.
  - Required response: no further drop.
- Calibration-abort scenario:
  - Stimulus: enter CAL, send 7 symbols, then drop `en`.
  - Required response: the state is IDLE, the thresholds are unchanged, and `cal_done` never pulses.
  - Stimulus continues: a re-entered calibration.
  - Required response: it counts a full 16 symbols.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared definitions for the 16-QAM demapper: FSM encodings, widths and the
// saturating magnitude used by both the controller and the datapath.
package qam_pkg;

    localparam int QAM_SYM_W = 8;
    localparam int QAM_VAL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // |x| for a signed symbol component; -128 has no positive twin and maps to 127.
    function automatic logic [QAM_SYM_W-1:0] sat_abs(input logic signed [QAM_SYM_W-1:0] x);
        logic [QAM_SYM_W-1:0] r;
        if (!x[QAM_SYM_W-1]) begin
            r = $unsigned(x);
        end else if ($unsigned(x) == {1'b1, {(QAM_SYM_W-1){1'b0}}}) begin
            r = {1'b0, {(QAM_SYM_W-1){1'b1}}};
        end else begin
            r = $unsigned(-x);
        end
        return r;
    endfunction

endpackage

// File: rtl/qam_demapper_ctrl_if.sv
// Output stream from the demapper controller toward the bit sink.
// Handshake: data_valid is high whenever data_out holds a value; the value is
// consumed at a rising edge where data_valid and data_ready are both high.
// data_ready may be high while data_valid is low (ignored); data_out reads 0
// while data_valid is low.
interface qam_demapper_ctrl_if;
    import qam_pkg::*;

    logic [QAM_VAL_W-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/qam_ctrl_fifo.sv
// Small synchronous FIFO for demapped values. Extra pointer bit separates full
// from empty; a push into a full FIFO is dropped unless a pop happens at the
// same edge, and any drop sets a sticky overflow flag. Head reads 0 when empty.
module qam_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         not_empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         overflow_q, overflow_d;
    logic         empty, full, do_pop, do_push;

    // Pointer arithmetic, write steering, drop detection and head selection.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
        do_pop     = pop & ~empty;
        do_push    = push & (~full | do_pop);
        wr_ptr_d   = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(do_pop);
        overflow_d = overflow_q | (push & ~do_push);
        mem_d      = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
        end
        rd_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        not_empty  = ~empty;
        overflow   = overflow_q;
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: rtl/qam_demapper_ctrl.sv
// Controller for the QAM demapper datapath: calibrates I/Q decision thresholds
// from the mean symbol magnitude, gates symbol loads into the datapath and
// buffers the returned 4-bit values for the downstream sink.
module qam_demapper_ctrl
    import qam_pkg::*;
#(
    parameter int             CAL_LEN        = 16,
    parameter int             FIFO_DEPTH     = 4,
    parameter logic [7:0]     DEFAULT_THRESH = 8'd32
) (
    input  logic                        symbol_clock,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        cal,
    input  logic                        sym_valid,
    input  logic signed [QAM_SYM_W-1:0] I_in,
    input  logic signed [QAM_SYM_W-1:0] Q_in,
    input  logic [QAM_VAL_W-1:0]        dp_val,
    output logic                        dp_load,
    output logic [QAM_SYM_W-1:0]        thresh_i,
    output logic [QAM_SYM_W-1:0]        thresh_q,
    qam_demapper_ctrl_if.master         out_if,
    output logic                        cal_done,
    output logic                        overflow,
    output state_t                      dbg_state
);
    localparam int CAL_W = $clog2(CAL_LEN);
    localparam int ACC_W = QAM_SYM_W + CAL_W;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [ACC_W-1:0]     sum_i, sum_q;
    logic [CAL_W-1:0]     cnt_q, cnt_d;
    logic [QAM_SYM_W-1:0] thresh_i_q, thresh_i_d, thresh_q_q, thresh_q_d;
    logic                 cal_done_q, cal_done_d;
    logic                 wr_pend_q, wr_pend_d;
    logic                 last_sym;

    // Next-state, calibration accumulation and load gating.
    always_comb begin
        state_d    = state_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        cnt_d      = cnt_q;
        thresh_i_d = thresh_i_q;
        thresh_q_d = thresh_q_q;
        cal_done_d = 1'b0;
        dp_load    = 1'b0;
        sum_i      = acc_i_q + ACC_W'(sat_abs(I_in));
        sum_q      = acc_q_q + ACC_W'(sat_abs(Q_in));
        last_sym   = sym_valid && (cnt_q == CAL_W'(CAL_LEN - 1));

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = cal ? ST_CAL : ST_RUN;
                end
            end
            ST_CAL: begin
                if (last_sym) begin
                    // Mean magnitude sits on the 2a decision boundary.
                    thresh_i_d = sum_i[ACC_W-1:CAL_W];
                    thresh_q_d = sum_q[ACC_W-1:CAL_W];
                    cal_done_d = 1'b1;
                    acc_i_d    = '0;
                    acc_q_d    = '0;
                    cnt_d      = '0;
                    state_d    = en ? ST_RUN : ST_IDLE;
                end else if (!en) begin
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (sym_valid) begin
                    acc_i_d = sum_i;
                    acc_q_d = sum_q;
                    cnt_d   = cnt_q + CAL_W'(1);
                end
            end
            ST_RUN: begin
                dp_load = sym_valid & en;
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (cal) begin
                    state_d = ST_CAL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The datapath result arrives one cycle after the load; remember to write it.
        wr_pend_d = dp_load;
    end

    // Controller state registers.
    always_ff @(posedge symbol_clock or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            cnt_q      <= '0;
            thresh_i_q <= DEFAULT_THRESH;
            thresh_q_q <= DEFAULT_THRESH;
            cal_done_q <= 1'b0;
            wr_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            cnt_q      <= cnt_d;
            thresh_i_q <= thresh_i_d;
            thresh_q_q <= thresh_q_d;
            cal_done_q <= cal_done_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

    qam_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (QAM_VAL_W)
    ) u_fifo (
        .clk       (symbol_clock),
        .rst       (rst),
        .push      (wr_pend_q),
        .push_data (dp_val),
        .pop       (out_if.data_ready),
        .rd_data   (out_if.data_out),
        .not_empty (out_if.data_valid),
        .overflow  (overflow)
    );

    assign thresh_i  = thresh_i_q;
    assign thresh_q  = thresh_q_q;
    assign cal_done  = cal_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_qam_demapper_ctrl.sv
// Bench for qam_demapper_ctrl: reset, calibration, saturation, streaming,
// overflow and calibration abort, with a scoreboard on the output stream.
module tb_qam_demapper_ctrl;
    import qam_pkg::*;

    localparam int CAL_LEN = 16;
    localparam int DEF_TH  = 32;

    // ---------------- clock / reset ----------------
    logic              symbol_clock = 1'b0;
    logic              rst          = 1'b1;
    logic              en           = 1'b0;
    logic              cal          = 1'b0;
    logic              sym_valid    = 1'b0;
    logic signed [7:0] i_in         = '0;
    logic signed [7:0] q_in         = '0;
    logic [3:0]        dp_val       = '0;
    logic              dp_load;
    logic [7:0]        thresh_i, thresh_q;
    logic              cal_done, overflow;
    state_t            dbg_state;

    qam_demapper_ctrl_if bus();

    always #5 symbol_clock = ~symbol_clock;

    qam_demapper_ctrl #(
        .CAL_LEN        (CAL_LEN),
        .FIFO_DEPTH     (4),
        .DEFAULT_THRESH (8'd32)
    ) dut (
        .symbol_clock (symbol_clock),
        .rst          (rst),
        .en           (en),
        .cal          (cal),
        .sym_valid    (sym_valid),
        .I_in         (i_in),
        .Q_in         (q_in),
        .dp_val       (dp_val),
        .dp_load      (dp_load),
        .thresh_i     (thresh_i),
        .thresh_q     (thresh_q),
        .out_if       (bus.master),
        .cal_done     (cal_done),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    // Datapath model: registers the low nibble of I as the demapped value.
    always @(posedge symbol_clock) begin
        if (dp_load) dp_val <= i_in[3:0];
    end

    // ---------------- checking ----------------
    int         n_checks   = 0;
    int         n_pass     = 0;
    int         cal_pulses = 0;
    int         exp_ti     = DEF_TH;
    int         exp_tq     = DEF_TH;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int model_abs(input int v);
        if (v >= 0) return v;
        if (v < -127) return 127;
        return -v;
    endfunction

    // Counts cal_done pulses; reads the value held over the previous cycle.
    always @(posedge symbol_clock) begin
        if (!rst && cal_done) cal_pulses++;
    end

    // Scoreboard: every accepted output value must match the oldest expected one.
    always @(negedge symbol_clock) begin
        if (!rst && bus.data_valid && bus.data_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'(bus.data_valid), 32'd0);
            end else begin
                check("sb_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge symbol_clock);
        #1;
    endtask

    // Expects the DUT already in CAL; sends CAL_LEN symbols, checks the result.
    task automatic run_cal(input int i0, input int i1, input int qv);
        int sum_i;
        int sum_q;
        int base;
        sum_i = 0;
        sum_q = 0;
        base  = cal_pulses;
        for (int k = 0; k < CAL_LEN; k++) begin
            int iv;
            iv        = (k % 2 == 0) ? i0 : i1;
            sym_valid = 1'b1;
            i_in      = 8'(iv);
            q_in      = 8'(qv);
            sum_i    += model_abs(iv);
            sum_q    += model_abs(qv);
            if (k == CAL_LEN - 1) begin
                cal = 1'b0;
                @(negedge symbol_clock);
                check("cal_no_early_pulse", 32'(cal_pulses), 32'(base));
                check("cal_done_low_before", 32'(cal_done), 32'd0);
                check("cal_state_before", 32'(dbg_state), 32'(ST_CAL));
                check("cal_dp_load_held", 32'(dp_load), 32'd0);
            end
            next_cycle();
        end
        sym_valid = 1'b0;
        exp_ti    = sum_i / CAL_LEN;
        exp_tq    = sum_q / CAL_LEN;
        @(negedge symbol_clock);
        check("cal_done_pulse", 32'(cal_done), 32'd1);
        check("cal_thresh_i", 32'(thresh_i), 32'(exp_ti));
        check("cal_thresh_q", 32'(thresh_q), 32'(exp_tq));
        check("cal_state_run", 32'(dbg_state), 32'(ST_RUN));
        next_cycle();
        @(negedge symbol_clock);
        check("cal_done_one_cycle", 32'(cal_done), 32'd0);
        check("cal_pulse_count", 32'(cal_pulses), 32'(base + 1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.data_ready = 1'b0;

        // Reset: outputs quiet, defaults applied, no load even with sym_valid.
        repeat (3) @(posedge symbol_clock);
        #1 sym_valid = 1'b1;
        @(negedge symbol_clock);
        check("rst_thresh_i", 32'(thresh_i), 32'(DEF_TH));
        check("rst_thresh_q", 32'(thresh_q), 32'(DEF_TH));
        check("rst_data_valid", 32'(bus.data_valid), 32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        check("rst_dp_load", 32'(dp_load), 32'd0);
        check("rst_cal_done", 32'(cal_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        next_cycle();
        rst = 1'b0;
        @(negedge symbol_clock);
        check("idle_dp_load", 32'(dp_load), 32'd0);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Calibration: I alternating +20/-60, Q constant -24.
        next_cycle();
        sym_valid = 1'b0;
        en        = 1'b1;
        cal       = 1'b1;
        next_cycle();
        run_cal(20, -60, -24);

        // Saturation: -128 must count as 127.
        next_cycle();
        cal = 1'b1;
        next_cycle();
        run_cal(-128, -128, 127);

        // Streaming: three back-to-back symbols, consumer always ready.
        next_cycle();
        bus.data_ready = 1'b1;
        next_cycle();
        sym_valid = 1'b1;
        i_in      = 8'h0A;
        exp_q.push_back(4'hA);
        @(negedge symbol_clock);
        check("stream_dp_load", 32'(dp_load), 32'd1);
        next_cycle();
        i_in = 8'h03;
        exp_q.push_back(4'h3);
        @(negedge symbol_clock);
        check("stream_latency", 32'(bus.data_valid), 32'd0);
        next_cycle();
        i_in = 8'h0F;
        exp_q.push_back(4'hF);
        @(negedge symbol_clock);
        check("stream_t2", 32'(bus.data_out), 32'hA);
        check("stream_t2_valid", 32'(bus.data_valid), 32'd1);
        next_cycle();
        sym_valid = 1'b0;
        @(negedge symbol_clock);
        check("stream_t3", 32'(bus.data_out), 32'h3);
        next_cycle();
        @(negedge symbol_clock);
        check("stream_t4", 32'(bus.data_out), 32'hF);
        next_cycle();
        @(negedge symbol_clock);
        check("stream_empty_valid", 32'(bus.data_valid), 32'd0);
        check("stream_empty_zero", 32'(bus.data_out), 32'd0);

        // Overflow: consumer stalled, five symbols into a four-entry FIFO.
        next_cycle();
        bus.data_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            sym_valid = (c < 5);
            i_in      = 8'(c + 1);
            if (c < 4) exp_q.push_back(4'(c + 1));
            @(negedge symbol_clock);
            if (c == 5) begin
                check("ovf_full_no_flag", 32'(overflow), 32'd0);
                check("ovf_full_valid", 32'(bus.data_valid), 32'd1);
            end
            if (c == 6) check("ovf_set", 32'(overflow), 32'd1);
            if (c == 7) begin
                check("ovf_sticky", 32'(overflow), 32'd1);
                check("ovf_head", 32'(bus.data_out), 32'd1);
            end
            next_cycle();
        end

        // Write and read at the same edge while full: nothing dropped.
        sym_valid = 1'b1;
        i_in      = 8'h06;
        exp_q.push_back(4'h6);
        next_cycle();
        sym_valid      = 1'b0;
        bus.data_ready = 1'b1;
        next_cycle();
        bus.data_ready = 1'b0;
        @(negedge symbol_clock);
        check("full_rw_head", 32'(bus.data_out), 32'd2);
        check("full_rw_valid", 32'(bus.data_valid), 32'd1);
        next_cycle();
        bus.data_ready = 1'b1;
        repeat (5) next_cycle();
        @(negedge symbol_clock);
        check("drain_valid", 32'(bus.data_valid), 32'd0);
        check("drain_zero", 32'(bus.data_out), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // Calibration abort after 7 symbols, then a full re-calibration.
        next_cycle();
        cal = 1'b1;
        next_cycle();
        @(negedge symbol_clock);
        check("abort_in_cal", 32'(dbg_state), 32'(ST_CAL));
        next_cycle();
        begin
            int base;
            base = cal_pulses;
            for (int k = 0; k < 7; k++) begin
                sym_valid = 1'b1;
                i_in      = 8'sd10;
                q_in      = 8'sd10;
                next_cycle();
            end
            sym_valid = 1'b0;
            en        = 1'b0;
            next_cycle();
            @(negedge symbol_clock);
            check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
            check("abort_thresh_i", 32'(thresh_i), 32'(exp_ti));
            check("abort_thresh_q", 32'(thresh_q), 32'(exp_tq));
            next_cycle();
            next_cycle();
            check("abort_no_pulse", 32'(cal_pulses), 32'(base));
        end
        en  = 1'b1;
        cal = 1'b1;
        next_cycle();
        run_cal(40, 40, -8);

        // Asynchronous reset mid-cycle clears at once.
        next_cycle();
        #2 rst = 1'b1;
        #1;
        check("async_rst_thresh_i", 32'(thresh_i), 32'(DEF_TH));
        check("async_rst_thresh_q", 32'(thresh_q), 32'(DEF_TH));
        check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("async_rst_overflow", 32'(overflow), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
